// File: rtl/i2c_stretch_slave.sv
// i2c_stretch_slave: I2C target that stretches SCL until user logic completes valid/ready byte handshakes.
// Optional stretch timeout with err_out pulse when `I2C_STRETCH_TIMEOUT_EN is defined.
module i2c_stretch_slave #(
  parameter int US = 100,
  parameter int I2C_MODE = 2,
  parameter logic [6:0] MYADDR = 7'h3b,
  parameter int STRETCH_MAX_US = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_out,
  output logic       sda_out,
  output logic [7:0] dat_out,
  output logic       ws_out,
  input  logic       ws_rdy,
  input  logic [7:0] dat_in,
  output logic       rs_out,
  input  logic       rs_ack,
  output logic       act_out,
  output logic       err_out
);
  localparam int TSU_NS = I2C_MODE == 0 ? 250 : I2C_MODE == 1 ? 100 : 50;
  localparam logic [15:0] TSU = 16'((US * TSU_NS) / 1000 + 1);
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_STRETCH, WR_ACK, RD_STRETCH, RD_DATA, RD_ACK, WAIT_STOP
  } state_t;
  state_t state, state_n;
  logic [2:0] scl_q, sda_q;
  logic [3:0] cnt, cnt_n;
  logic [7:0] sr, sr_n, dat_n;
  logic [15:0] tmr, tmr_n;
  logic ws_n, rs_n, act_n, scl_n, sda_n, err_n;
  logic scl_s, scl_p, sda_s, sda_p, rise, fall, start, stop, acc, hit, tmo;
  assign scl_s = scl_q[1];
  assign scl_p = scl_q[2];
  assign sda_s = sda_q[1];
  assign sda_p = sda_q[2];
  assign rise  = scl_s & ~scl_p;
  assign fall  = ~scl_s & scl_p;
  assign start = scl_s & scl_p & sda_p & ~sda_s;
  assign stop  = scl_s & scl_p & ~sda_p & sda_s;
  assign acc   = ws_out & ws_rdy;
  assign hit   = sr[7:1] == MYADDR;
`ifdef I2C_STRETCH_TIMEOUT_EN
  localparam logic [31:0] SC_MAX = 32'(STRETCH_MAX_US * US - 1);
  logic [31:0] sc;
  // counts only while we hold SCL low, so it restarts at every stretch entry
  always_ff @(posedge clk or posedge rst)
    if (rst) sc <= '0;
    else sc <= scl_out ? '0 : sc + 32'd1;
  assign tmo = ~scl_out & (sc == SC_MAX);
`else
  logic unused_cfg;
  assign unused_cfg = ^32'(STRETCH_MAX_US);
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      scl_q <= '1;
      sda_q <= '1;
      state <= IDLE;
      cnt <= '0;
      sr <= '0;
      dat_out <= '0;
      tmr <= '0;
      ws_out <= 1'b0;
      rs_out <= 1'b0;
      act_out <= 1'b0;
      scl_out <= 1'b1;
      sda_out <= 1'b1;
      err_out <= 1'b0;
    end else begin
      scl_q <= {scl_q[1:0], scl_in};
      sda_q <= {sda_q[1:0], sda_in};
      state <= state_n;
      cnt <= cnt_n;
      sr <= sr_n;
      dat_out <= dat_n;
      tmr <= tmr_n;
      ws_out <= ws_n;
      rs_out <= rs_n;
      act_out <= act_n;
      scl_out <= scl_n;
      sda_out <= sda_n;
      err_out <= err_n;
    end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sr_n = sr;
    dat_n = dat_out;
    tmr_n = tmr;
    ws_n = ws_out & ~ws_rdy;
    rs_n = rs_out & ~rs_ack;
    act_n = act_out;
    scl_n = scl_out;
    sda_n = sda_out;
    err_n = 1'b0;
    if (start | stop) begin
      state_n = start ? ADDR : IDLE;
      cnt_n = '0;
      ws_n = 1'b0;
      rs_n = 1'b0;
      act_n = 1'b0;
      scl_n = 1'b1;
      sda_n = 1'b1;
    end else begin
      case (state)
        ADDR:
          if (rise) begin
            sr_n = {sr[6:0], sda_s};
            cnt_n = cnt + 4'd1;
          end else if (fall && cnt == 4'd8) begin
            state_n = hit ? ADDR_ACK : WAIT_STOP;
            act_n = hit;
            sda_n = ~hit;
          end
        ADDR_ACK:
          if (fall) begin
            state_n = sr[0] ? RD_STRETCH : WR_DATA;
            cnt_n = '0;
            sda_n = 1'b1;
            rs_n = sr[0];
            scl_n = ~sr[0];
          end
        WR_DATA:
          if (rise) begin
            sr_n = {sr[6:0], sda_s};
            cnt_n = cnt + 4'd1;
            if (cnt == 4'd7) begin
              dat_n = {sr[6:0], sda_s};
              ws_n = 1'b1;
            end
          end else if (fall && cnt == 4'd8) begin
            // an already-accepted byte is ACKed straight away without stretching
            state_n = ws_n ? WR_STRETCH : WR_ACK;
            scl_n = ~ws_n;
            sda_n = ws_n;
          end
        WR_STRETCH:
          if (tmo) begin
            state_n = WAIT_STOP;
            ws_n = 1'b0;
            sda_n = 1'b1;
            scl_n = 1'b1;
            err_n = 1'b1;
          end else if (ws_out) begin
            if (acc) begin
              sda_n = 1'b0;
              tmr_n = TSU - 16'd1;
            end
          end else if (tmr == '0) begin
            state_n = WR_ACK;
            scl_n = 1'b1;
          end else tmr_n = tmr - 16'd1;
        WR_ACK:
          if (fall) begin
            state_n = WR_DATA;
            cnt_n = '0;
            sda_n = 1'b1;
          end
        RD_STRETCH:
          if (tmo) begin
            state_n = RD_DATA;
            rs_n = 1'b0;
            sr_n = 8'hff;
            cnt_n = '0;
            sda_n = 1'b1;
            scl_n = 1'b1;
            err_n = 1'b1;
          end else if (rs_out) begin
            if (rs_ack) begin
              sr_n = dat_in;
              sda_n = dat_in[7];
              tmr_n = TSU - 16'd1;
            end
          end else if (tmr == '0) begin
            state_n = RD_DATA;
            cnt_n = '0;
            scl_n = 1'b1;
          end else tmr_n = tmr - 16'd1;
        RD_DATA:
          if (fall) begin
            state_n = cnt == 4'd7 ? RD_ACK : RD_DATA;
            sda_n = cnt == 4'd7 ? 1'b1 : sr[6];
            sr_n = {sr[6:0], 1'b0};
            cnt_n = cnt + 4'd1;
          end
        RD_ACK:
          if (rise) sr_n[0] = sda_s;
          else if (fall) begin
            state_n = sr[0] ? WAIT_STOP : RD_STRETCH;
            rs_n = ~sr[0];
            scl_n = sr[0];
          end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_stretch_slave.sv
// tb_i2c_stretch_slave: bit-banged I2C master plus valid/ready user responders around i2c_stretch_slave.
module tb_i2c_stretch_slave;
  localparam int Q = 25;
  logic clk = 1'b0, rst = 1'b1, m_scl = 1'b1, m_sda = 1'b1;
  logic ws_rdy = 1'b0, rs_ack = 1'b0;
  logic [7:0] dat_in = '0;
  logic scl_out, sda_out, ws_out, rs_out, act_out, err_out, scl_line, sda_line;
  logic [7:0] dat_out;
  logic [7:0] rd_vals [2] = '{8'h55, 8'h56};
  int n_chk = 0, n_fail = 0, rdy_delay = 0, ri = 0;
  int ws_acc = 0, rs_req = 0, rs_hs = 0, err_cnt = 0, scl_low = 0, sda_low = 0, run = 0, last_stretch = 0;
  logic rs_p = 1'b0;
  assign scl_line = m_scl & scl_out;
  assign sda_line = m_sda & sda_out;
  i2c_stretch_slave #(.US(100), .I2C_MODE(2), .MYADDR(7'h3b), .STRETCH_MAX_US(5)) dut (
    .clk(clk), .rst(rst), .scl_in(scl_line), .sda_in(sda_line), .scl_out(scl_out), .sda_out(sda_out),
    .dat_out(dat_out), .ws_out(ws_out), .ws_rdy(ws_rdy), .dat_in(dat_in), .rs_out(rs_out),
    .rs_ack(rs_ack), .act_out(act_out), .err_out(err_out)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  always @(negedge clk)
    if (!rst) begin
      if (ws_out && ws_rdy) ws_acc++;
      if (rs_out && !rs_p) rs_req++;
      if (rs_out && rs_ack) rs_hs++;
      rs_p = rs_out;
      if (err_out) err_cnt++;
      if (!sda_out) sda_low++;
      if (!scl_out) begin
        scl_low++;
        run++;
      end else if (run != 0) begin
        last_stretch = run;
        run = 0;
      end
    end
  initial forever begin
    @(negedge clk);
    if (ws_out && !ws_rdy) begin
      repeat (rdy_delay) @(negedge clk);
      ws_rdy = 1'b1;
      @(negedge clk);
      ws_rdy = 1'b0;
    end
  end
  initial forever begin
    @(negedge clk);
    if (rs_out && !rs_ack) begin
      repeat (10) @(negedge clk);
      dat_in = rd_vals[ri[0]];
      ri++;
      rs_ack = 1'b1;
      @(negedge clk);
      rs_ack = 1'b0;
    end
  end
  initial begin
    repeat (150000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish in 150000 cycles");
    $fatal(1);
  end
  task automatic w(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic scl_hi();
    int k;
    k = 0;
    m_scl = 1'b1;
    while (scl_line !== 1'b1 && k < 10000) begin
      @(negedge clk);
      k++;
    end
    if (scl_line !== 1'b1) check("scl_release", 32'(scl_line), 1);
  endtask
  task automatic i2c_start();
    m_sda = 1'b1; w(Q); scl_hi(); w(Q);
    m_sda = 1'b0; w(Q);
    m_scl = 1'b0; w(Q);
  endtask
  task automatic i2c_stop();
    m_sda = 1'b0; w(Q); scl_hi(); w(Q);
    m_sda = 1'b1; w(Q);
  endtask
  task automatic put_bit(input logic b);
    m_sda = b; w(Q); scl_hi(); w(2 * Q);
    m_scl = 1'b0; w(Q);
  endtask
  task automatic get_bit(output logic b);
    m_sda = 1'b1; w(Q); scl_hi(); w(Q);
    b = sda_line; w(Q);
    m_scl = 1'b0; w(Q);
  endtask
  task automatic put_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(ack);
  endtask
  task automatic get_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 0; i < 8; i++) begin
      get_bit(b);
      d = {d[6:0], b};
    end
    put_bit(nack);
  endtask
  initial begin
    logic ack;
    logic [7:0] d;
    int b0, b1, b2, b3;
    w(5);
    check("rst_scl_out", 32'(scl_out), 1);
    check("rst_sda_out", 32'(sda_out), 1);
    check("rst_ws_out", 32'(ws_out), 0);
    check("rst_rs_out", 32'(rs_out), 0);
    check("rst_dat_out", 32'(dat_out), 0);
    check("rst_act_out", 32'(act_out), 0);
    check("rst_err_out", 32'(err_out), 0);
    rst = 1'b0;
    w(10);
    // plain write, user always ready
    b0 = ws_acc; b1 = scl_low;
    i2c_start();
    put_byte(8'h76, ack);
    check("t1_addr_ack", 32'(ack), 0);
    check("t1_act_on", 32'(act_out), 1);
    put_byte(8'haa, ack);
    check("t1_data_ack", 32'(ack), 0);
    i2c_stop(); w(10);
    check("t1_accepts", 32'(ws_acc - b0), 1);
    check("t1_dat_out", 32'(dat_out), 32'h aa);
    check("t1_act_off", 32'(act_out), 0);
    check("t1_no_stretch", 32'(scl_low - b1), 0);
`ifndef I2C_STRETCH_TIMEOUT_EN
    // user answers 40us late: SCL held low meanwhile
    rdy_delay = 4000; b0 = ws_acc;
    i2c_start();
    put_byte(8'h76, ack);
    put_byte(8'h3c, ack);
    check("t2_data_ack", 32'(ack), 0);
    i2c_stop(); w(10);
    check("t2_stretch_len", 32'(last_stretch >= 3800 && last_stretch <= 4100), 1);
    check("t2_accepts", 32'(ws_acc - b0), 1);
    check("t2_dat_out", 32'(dat_out), 32'h3c);
    rdy_delay = 0;
`endif
    // read two bytes, ACK then NACK
    b2 = rs_req; b3 = rs_hs;
    i2c_start();
    put_byte(8'h77, ack);
    check("t3_addr_ack", 32'(ack), 0);
    get_byte(1'b0, d);
    check("t3_rd0", 32'(d), 32'h55);
    get_byte(1'b1, d);
    check("t3_rd1", 32'(d), 32'h56);
    i2c_stop(); w(20);
    check("t3_rs_requests", 32'(rs_req - b2), 2);
    check("t3_rs_handshakes", 32'(rs_hs - b3), 2);
    // foreign address: bus untouched
    b0 = ws_acc; b1 = scl_low; b2 = sda_low; b3 = rs_req;
    i2c_start();
    put_byte(8'h74, ack);
    check("t4_nack", 32'(ack), 1);
    check("t4_act", 32'(act_out), 0);
    i2c_stop(); w(10);
    check("t4_sda_untouched", 32'(sda_low - b2), 0);
    check("t4_scl_untouched", 32'(scl_low - b1), 0);
    check("t4_no_ws", 32'(ws_acc - b0), 0);
    check("t4_no_rs", 32'(rs_req - b3), 0);
    // repeated START after three data bits
    b0 = ws_acc;
    i2c_start();
    put_byte(8'h76, ack);
    put_bit(1'b1); put_bit(1'b0); put_bit(1'b1);
    i2c_start();
    check("t5_no_accept", 32'(ws_acc - b0), 0);
    check("t5_ws_out", 32'(ws_out), 0);
    put_byte(8'h76, ack);
    check("t5_addr_ack", 32'(ack), 0);
    put_byte(8'h11, ack);
    check("t5_data_ack", 32'(ack), 0);
    i2c_stop(); w(10);
    check("t5_accepts", 32'(ws_acc - b0), 1);
    check("t5_dat_out", 32'(dat_out), 32'h11);
`ifdef I2C_STRETCH_TIMEOUT_EN
    // user never answers: 5us timeout releases SCL and NACKs
    rdy_delay = 200000; b0 = ws_acc; b1 = err_cnt;
    i2c_start();
    put_byte(8'h76, ack);
    put_byte(8'h5a, ack);
    check("t6_nack", 32'(ack), 1);
    check("t6_stretch_len", 32'(last_stretch >= 490 && last_stretch <= 510), 1);
    i2c_stop(); w(10);
    check("t6_err_pulses", 32'(err_cnt - b1), 1);
    check("t6_no_accept", 32'(ws_acc - b0), 0);
`else
    // without the timeout, SCL stays low until the user is ready
    rdy_delay = 6000; b0 = ws_acc;
    i2c_start();
    put_byte(8'h76, ack);
    put_byte(8'h5a, ack);
    check("t6_data_ack", 32'(ack), 0);
    check("t6_stretch_len", 32'(last_stretch >= 5800 && last_stretch <= 6100), 1);
    i2c_stop(); w(10);
    check("t6_accepts", 32'(ws_acc - b0), 1);
    check("t6_err_never", 32'(err_cnt), 0);
    rdy_delay = 0;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
